// File: rtl/anim_sequencer.sv
// Control FSM for the VGA animation pipeline: background, per-object coordinates, plot/erase, frame pacing.
// Defining ANIM_SEQ_CLEAR_EN adds the CLEAR state driven by the black input.
module anim_sequencer #(
  parameter int unsigned NUM_OBJ         = 4,
  parameter int unsigned STEPS           = 16,
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned OBJ_W           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             black,
  input  logic             bg_done,
  input  logic             draw_done,
  input  logic             erase_done,
  input  logic             frame_tick,
  output logic             ld_bg,
  output logic             ld_coord,
  output logic             ld_plot,
  output logic             ld_erase,
  output logic             ld_clear,
  output logic [OBJ_W-1:0] obj_sel,
  output logic             round_done,
  output logic             busy
);

  localparam int unsigned StepW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned FrameW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [OBJ_W-1:0]  LastObj   = OBJ_W'(NUM_OBJ - 1);
  localparam logic [StepW-1:0]  LastStep  = StepW'(STEPS - 1);
  localparam logic [FrameW-1:0] LastFrame = FrameW'(FRAMES_PER_STEP - 1);

`ifdef ANIM_SEQ_CLEAR_EN
  typedef enum logic [2:0] {
    StIdle, StDrawBg, StGenLoc, StPlot, StWaitFrame, StErase, StDone, StClear
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StDrawBg, StGenLoc, StPlot, StWaitFrame, StErase, StDone
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [OBJ_W-1:0]   sel_q, sel_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [FrameW-1:0]  frame_q, frame_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      step_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = step_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = StDrawBg;
      end
      StDrawBg: begin
        if (bg_done) begin
          state_d = StGenLoc;
          sel_d   = '0;
        end
      end
      StGenLoc: begin
        if (sel_q != LastObj) begin
          sel_d = sel_q + 1'b1;
        end else begin
          state_d = StPlot;
          sel_d   = '0;
        end
      end
      StPlot: begin
        if (draw_done) begin
          if (sel_q != LastObj) begin
            sel_d = sel_q + 1'b1;
          end else begin
            state_d = StWaitFrame;
            sel_d   = '0;
            frame_d = '0;
          end
        end
      end
      StWaitFrame: begin
        // frame_cnt holds at its terminal value on the leaving tick; PLOT re-zeroes it.
        if (frame_tick) begin
          if (frame_q != LastFrame) begin
            frame_d = frame_q + 1'b1;
          end else if (step_q == LastStep) begin
            state_d = StDone;
          end else begin
            state_d = StErase;
            step_d  = step_q + 1'b1;
          end
        end
      end
      StErase: begin
        if (erase_done) begin
          if (sel_q != LastObj) begin
            sel_d = sel_q + 1'b1;
          end else begin
            state_d = StGenLoc;
            sel_d   = '0;
          end
        end
      end
      StDone: begin
        step_d  = '0;
        state_d = StDrawBg;
      end
`ifdef ANIM_SEQ_CLEAR_EN
      StClear: begin
        if (erase_done) state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef ANIM_SEQ_CLEAR_EN
    // black overrides any completion pulse seen in the same cycle.
    if (black && (state_q inside {StPlot, StWaitFrame, StErase})) begin
      state_d = StClear;
      sel_d   = '0;
      step_d  = '0;
      frame_d = '0;
    end
`endif
  end

`ifndef ANIM_SEQ_CLEAR_EN
  logic unused_black;
  assign unused_black = black;
`endif

  always_comb begin
    ld_bg      = 1'b0;
    ld_coord   = 1'b0;
    ld_plot    = 1'b0;
    ld_erase   = 1'b0;
    ld_clear   = 1'b0;
    round_done = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StDrawBg: ld_bg      = 1'b1;
      StGenLoc: ld_coord   = 1'b1;
      StPlot:   ld_plot    = 1'b1;
      StErase:  ld_erase   = 1'b1;
      StDone:   round_done = 1'b1;
`ifdef ANIM_SEQ_CLEAR_EN
      StClear:  ld_clear   = 1'b1;
`endif
      default: ;
    endcase
  end

  assign obj_sel = sel_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Randomized directed bench for anim_sequencer (NUM_OBJ=4, STEPS=3, FRAMES_PER_STEP=2).
module tb_anim_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned S = 3;
  localparam int unsigned F = 2;

  // Expected flag vectors: {ld_bg, ld_coord, ld_plot, ld_erase, ld_clear, round_done, busy}
  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_BG    = 7'b1000001;
  localparam logic [6:0] E_COORD = 7'b0100001;
  localparam logic [6:0] E_PLOT  = 7'b0010001;
  localparam logic [6:0] E_ERASE = 7'b0001001;
  localparam logic [6:0] E_CLEAR = 7'b0000101;
  localparam logic [6:0] E_DONE  = 7'b0000011;
  localparam logic [6:0] E_WAIT  = 7'b0000001;

  // Input vectors: {go, black, bg_done, draw_done, erase_done, frame_tick}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_GO    = 6'b100000;
  localparam logic [5:0] I_BLACK = 6'b010000;
  localparam logic [5:0] I_BG    = 6'b001000;
  localparam logic [5:0] I_DRAW  = 6'b000100;
  localparam logic [5:0] I_ERASE = 6'b000010;
  localparam logic [5:0] I_TICK  = 6'b000001;

  // Inputs each state must ignore.
  localparam logic [5:0] M_BG    = 6'b110111;
  localparam logic [5:0] M_ANY   = 6'b111111;
  localparam logic [5:0] M_PLOT  = 6'b101011;
  localparam logic [5:0] M_WAIT  = 6'b101110;
  localparam logic [5:0] M_ERASE = 6'b101101;

  logic       clk = 1'b0;
  logic       reset, go, black, bg_done, draw_done, erase_done, frame_tick;
  logic       ld_bg, ld_coord, ld_plot, ld_erase, ld_clear, round_done, busy;
  logic [1:0] obj_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  anim_sequencer #(
    .NUM_OBJ(N),
    .STEPS(S),
    .FRAMES_PER_STEP(F)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .black(black),
    .bg_done(bg_done),
    .draw_done(draw_done),
    .erase_done(erase_done),
    .frame_tick(frame_tick),
    .ld_bg(ld_bg),
    .ld_coord(ld_coord),
    .ld_plot(ld_plot),
    .ld_erase(ld_erase),
    .ld_clear(ld_clear),
    .obj_sel(obj_sel),
    .round_done(round_done),
    .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] noise(input logic [5:0] mask);
    return 6'($urandom) & 6'($urandom) & mask;
  endfunction

  task automatic drive(input logic [5:0] v);
    {go, black, bg_done, draw_done, erase_done, frame_tick} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] ef, input logic [1:0] es);
    logic [6:0] af;
    af = {ld_bg, ld_coord, ld_plot, ld_erase, ld_clear, round_done, busy};
    checks++;
    assert (af === ef) else begin
      errors++;
      $error("FAIL %s flags observed=%b expected=%b", tag, af, ef);
    end
    checks++;
    assert (obj_sel === es) else begin
      errors++;
      $error("FAIL %s obj_sel observed=%0d expected=%0d", tag, obj_sel, es);
    end
  endtask

  // Continues GEN_LOC from object 1 (object 0 already checked) into PLOT.
  task automatic gen_loc_rest();
    for (int i = 1; i < N; i++) begin
      drive(noise(M_ANY));
      expect_out("genloc", E_COORD, 2'(i));
    end
    drive(noise(M_ANY));
    expect_out("genloc_exit", E_PLOT, 2'd0);
  endtask

  // From DRAW_BG through GEN_LOC to PLOT object 0.
  task automatic do_bg();
    repeat ($urandom_range(0, 3)) begin
      drive(noise(M_BG));
      expect_out("bg_wait", E_BG, 2'd0);
    end
    drive(I_BG | noise(M_BG));
    expect_out("genloc0", E_COORD, 2'd0);
    gen_loc_rest();
  endtask

  task automatic do_plot();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        drive(noise(M_PLOT));
        expect_out("plot_wait", E_PLOT, 2'(i));
      end
      drive(I_DRAW | noise(M_PLOT));
      if (i < N - 1) expect_out("plot_adv", E_PLOT, 2'(i + 1));
      else expect_out("plot_exit", E_WAIT, 2'd0);
    end
  endtask

  task automatic do_wait(input bit last);
    for (int t = 0; t < F; t++) begin
      repeat ($urandom_range(0, 3)) begin
        drive(noise(M_WAIT));
        expect_out("frame_wait", E_WAIT, 2'd0);
      end
      drive(I_TICK | noise(M_WAIT));
      if (t < F - 1) expect_out("frame_tick", E_WAIT, 2'd0);
      else if (last) expect_out("round_done", E_DONE, 2'd0);
      else expect_out("to_erase", E_ERASE, 2'd0);
    end
    if (last) begin
      drive(noise(M_ANY));
      expect_out("restart_bg", E_BG, 2'd0);
    end
  endtask

  task automatic do_erase();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        drive(noise(M_ERASE));
        expect_out("erase_wait", E_ERASE, 2'(i));
      end
      drive(I_ERASE | noise(M_ERASE));
      if (i < N - 1) expect_out("erase_adv", E_ERASE, 2'(i + 1));
      else expect_out("erase_exit", E_COORD, 2'd0);
    end
    gen_loc_rest();
  endtask

  // Full round starting in DRAW_BG, ending in DRAW_BG of the next round.
  task automatic run_round();
    do_bg();
    for (int s = 0; s < S; s++) begin
      do_plot();
      do_wait(s == S - 1);
      if (s != S - 1) do_erase();
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) begin
      drive(I_GO);
      expect_out("reset", E_IDLE, 2'd0);
    end
    reset = 1'b0;
    drive(I_NONE);
    expect_out("idle", E_IDLE, 2'd0);
    drive(I_GO);
    expect_out("go", E_BG, 2'd0);

    run_round();
    run_round();

    // Completion pulses not owned by PLOT, then a held draw_done.
    do_bg();
    drive(I_BG);
    expect_out("plot_ign_bg", E_PLOT, 2'd0);
    drive(I_ERASE);
    expect_out("plot_ign_erase", E_PLOT, 2'd0);
    for (int i = 1; i <= N; i++) begin
      drive(I_DRAW);
      if (i < N) expect_out("held_draw", E_PLOT, 2'(i));
      else expect_out("held_draw_exit", E_WAIT, 2'd0);
    end
    drive(I_TICK);
    expect_out("tick1", E_WAIT, 2'd0);
    drive(I_TICK);
    expect_out("tick2", E_ERASE, 2'd0);
    drive(I_ERASE);
    expect_out("erase1", E_ERASE, 2'd1);
    drive(I_ERASE);
    expect_out("erase2", E_ERASE, 2'd2);

    // Reset mid-ERASE, then a full round must again take S steps.
    reset = 1'b1;
    drive(I_ERASE);
    expect_out("mid_reset", E_IDLE, 2'd0);
    reset = 1'b0;
    drive(I_NONE);
    expect_out("post_reset_idle", E_IDLE, 2'd0);
    drive(I_GO);
    expect_out("rego", E_BG, 2'd0);
    run_round();

    // black coincident with draw_done in PLOT.
    do_bg();
    drive(I_BLACK | I_DRAW);
`ifdef ANIM_SEQ_CLEAR_EN
    expect_out("black_plot", E_CLEAR, 2'd0);
    drive(I_DRAW);
    expect_out("clear_hold", E_CLEAR, 2'd0);
    drive(I_ERASE);
    expect_out("clear_exit", E_IDLE, 2'd0);
    drive(I_GO);
    expect_out("clear_rego", E_BG, 2'd0);
`else
    expect_out("black_plot", E_PLOT, 2'd1);
    drive(I_BLACK);
    expect_out("black_ignored", E_PLOT, 2'd1);
    reset = 1'b1;
    drive(I_NONE);
    expect_out("reset2", E_IDLE, 2'd0);
    reset = 1'b0;
    drive(I_GO);
    expect_out("rego2", E_BG, 2'd0);
`endif

    // black with frame_tick in WAIT_FRAME.
    do_bg();
    do_plot();
    drive(I_BLACK | I_TICK);
`ifdef ANIM_SEQ_CLEAR_EN
    expect_out("black_wait", E_CLEAR, 2'd0);
    drive(I_ERASE);
    expect_out("black_wait_exit", E_IDLE, 2'd0);
`else
    expect_out("black_wait", E_WAIT, 2'd0);
    drive(I_TICK);
    expect_out("black_wait_tick", E_ERASE, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
